dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single data-memory port (byte/halfword/word, combinational read, clocked write) between two requesters. Port 0 is the core load/store unit; port 1 is a secondary master (DMA/debug). The arbiter uses priority to port 0 with a starvation guard and supports locked back-to-back sequences (read-modify-write). It returns registered responses one cycle after grant. It sits between the requesters and the memory instance and drives all memory inputs.

Parameters:
StarveLimit, 4, max consecutive port-0 grants while port 1 waits before port 1 is forced a grant (1..15)
AddrWidth, DMemAddrWidth (config_pkg), memory byte-address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_i[2]  in  2  request valid per port
lock_i[2]  in  2  keep grant after this transfer
we_i[2]  in  2  write request per port
width_i[2]  in  mem_width_t  access width (BYTE/HALFWORD/WORD)
sext_i[2]  in  2  sign-extend loads
addr_i[2]  in  AddrWidth  byte address
wdata_i[2]  in  32  write data
gnt_o[2]  out  2  grant (combinational); transfer = req_i & gnt_o
rsp_valid_o[2]  out  2  response valid, one cycle after transfer
rsp_data_o[2]  out  32  load data (0 for writes)
rsp_err_o[2]  out  2  alignment error of that transfer
mem_we_o  out  1  to memory write_enable
mem_width_o  out  mem_width_t  to memory width
mem_sext_o  out  1  to memory sign_extend
mem_addr_o  out  AddrWidth  to memory address
mem_wdata_o  out  32  to memory data_in
mem_rdata_i  in  32  from memory data_out
mem_align_err_i  in  1  from memory alignment_error

Behaviour:
- Reset: as a decided fact, clk is the single clock and reset is asynchronous and active-high. It forces state IDLE, starve counter 0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0. A reset mid-lock drops the lock, and any pending response is lost.
- States:
  - IDLE: no lock.
  - LOCK0, LOCK1: grant is pinned to that port.
- Grant in IDLE:
  - Only req_i[0] set: port 0 is granted.
  - Only req_i[1] set: port 1 is granted.
  - Both set: port 0 is granted unless starve counter == StarveLimit, in which case port 1 is granted.
  - At most one gnt_o bit is ever high.
- Grant in LOCKn: gnt_o[n]=req_i[n]; the other port is never granted, even if port n is idle.
- Transitions:
  - A transfer with lock_i=1 moves to LOCKn.
  - A transfer on port n with lock_i=0 while in LOCKn returns to IDLE.
  - A lock held by port 1 is not counted as starvation of port 0.
- Starve counter:
  - Increments (saturating at StarveLimit) on each port-0 transfer while req_i[1]=1.
  - Clears on any port-1 transfer.
  - Clears when req_i[1]=0.
- Memory mux:
  - mem_*_o are driven from the granted port; no grant drives all zeros.
  - mem_we_o = we_i[g] & req_i[g] & gnt_o[g].
  - Address, width and wdata are combinational passthrough.
- Response:
  - On a transfer at cycle N, mem_rdata_i and mem_align_err_i are registered.
  - rsp_valid_o[g]=1 in cycle N+1 for exactly one cycle.
  - rsp_data_o holds the captured read data for loads, 0 for writes, and holds its value until the next response on that port.
- Throughput: one transfer per cycle. Back-to-back transfers from the same or alternating ports are legal, and a response and a new grant can coincide.
- Requesters must hold req/addr/data stable until granted. The arbiter does not check this.

Optional Feature:
DMEM_ARB_ALIGN_BLOCK_EN
- Defined: a misaligned write (HALFWORD with addr[0]=1, WORD with addr[1:0]!=0) has mem_we_o forced to 0. The transfer still completes, with rsp_err_o=1 at N+1.
- Undefined: mem_we_o is passed through and the memory performs the write despite the error. rsp_err_o is still reported.

Test Plan:
- Port 0 WORD write of 0xDEADBEEF to addr 0x10, then BYTE signed load from addr 0x13 -> gnt_o[0] each cycle; second rsp_data_o[0]=0xFFFFFFDE one cycle after grant, rsp_err_o=0.
- req_i=2'b11 continuously, StarveLimit=4 -> grants are 0,0,0,0,1,0,0,0,0,1…; counter clears after each port-1 grant.
- Port 1 locked sequence: load addr 0x20 with lock=1, port 0 requesting meanwhile, then store 0x5 to 0x20 with lock=0 -> port 0 is blocked for both cycles and granted on the cycle after the unlock; memory word 0x20 equals 0x5.
- Port 0 HALFWORD write to addr 0x21 with data 0xABCD over memory word 0x11223344 at 0x20 -> rsp_err_o[0]=1. With DMEM_ARB_ALIGN_BLOCK_EN the word stays 0x11223344; without it the memory writes the halfword.
- Assert reset while in LOCK0 with a response pending -> rsp_valid_o=0 immediately (asynchronous). After release, a port-1 request is granted in the first cycle.
- No requests for 3 cycles -> gnt_o=0, mem_we_o=0, mem_addr_o=0, rsp_valid_o=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core LSU (port 0)
// and a secondary master (port 1, DMA/debug).
//
// Port 0 has priority; a starvation counter forces a port-1 grant after
// StarveLimit consecutive port-0 transfers while port 1 waits. A transfer
// with lock set pins the grant to that port until it transfers with lock
// clear. Responses are registered one cycle after the transfer.
//
// Optional feature macro: DMEM_ARB_ALIGN_BLOCK_EN
//   defined   - misaligned writes have mem_we_o forced low (error still reported)
//   undefined - misaligned writes pass through to the memory
//
// Handshake: a transfer on port n happens in any cycle where req_i[n] and
// gnt_o[n] are both high. Requesters hold req/addr/data stable until that
// cycle; the response for the transfer is rsp_valid_o[n] in the next cycle.

package config_pkg;
  localparam int DMemAddrWidth = 12;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } mem_width_t;
endpackage

module dmem_arbiter
  import config_pkg::*;
#(
  parameter int StarveLimit = 4,
  parameter int AddrWidth   = DMemAddrWidth
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_i,
  input  logic [1:0]           lock_i,
  input  logic [1:0]           we_i,
  input  mem_width_t           width_i     [2],
  input  logic [1:0]           sext_i,
  input  logic [AddrWidth-1:0] addr_i      [2],
  input  logic [31:0]          wdata_i     [2],
  output logic [1:0]           gnt_o,
  output logic [1:0]           rsp_valid_o,
  output logic [31:0]          rsp_data_o  [2],
  output logic [1:0]           rsp_err_o,
  output logic                 mem_we_o,
  output mem_width_t           mem_width_o,
  output logic                 mem_sext_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 mem_align_err_i,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [3:0] Limit = 4'(StarveLimit);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [1:0] xfer;
  logic       sel;
  logic       any_gnt;

  assign dbg_state_o = state;

  // Grant selection: lock pins the grant, otherwise port 0 wins unless starved out
  always_comb begin
    gnt_o = 2'b00;
    case (state)
      IDLE: begin
        if (req_i == 2'b11) begin
          gnt_o = (starve_cnt == Limit) ? 2'b10 : 2'b01;
        end else begin
          gnt_o = req_i;
        end
      end
      LOCK0:   gnt_o = {1'b0, req_i[0]};
      LOCK1:   gnt_o = {req_i[1], 1'b0};
      default: gnt_o = 2'b00;
    endcase
  end

  assign xfer    = req_i & gnt_o;
  assign sel     = gnt_o[1];
  assign any_gnt = |gnt_o;

`ifdef DMEM_ARB_ALIGN_BLOCK_EN
  logic misaligned;

  // Alignment of the granted access, used to suppress misaligned writes
  always_comb begin
    misaligned = 1'b0;
    case (width_i[sel])
      HALFWORD: misaligned = addr_i[sel][0];
      WORD:     misaligned = (addr_i[sel][1:0] != 2'b00);
      default:  misaligned = 1'b0;
    endcase
  end
`endif

  // Memory mux: granted port drives the memory, no grant drives zeros
  always_comb begin
    mem_we_o    = 1'b0;
    mem_width_o = BYTE;
    mem_sext_o  = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (any_gnt) begin
      mem_we_o    = we_i[sel] & xfer[sel];
      mem_width_o = width_i[sel];
      mem_sext_o  = sext_i[sel];
      mem_addr_o  = addr_i[sel];
      mem_wdata_o = wdata_i[sel];
`ifdef DMEM_ARB_ALIGN_BLOCK_EN
      if (misaligned) begin
        mem_we_o = 1'b0;
      end
`endif
    end
  end

  // Lock state machine and starvation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      if (xfer[0]) begin
        if (lock_i[0]) begin
          state <= LOCK0;
        end else if (state == LOCK0) begin
          state <= IDLE;
        end
      end else if (xfer[1]) begin
        if (lock_i[1]) begin
          state <= LOCK1;
        end else if (state == LOCK1) begin
          state <= IDLE;
        end
      end

      // port 1 being served or not waiting ends any starvation streak
      if (xfer[1] || !req_i[1]) begin
        starve_cnt <= 4'd0;
      end else if (xfer[0] && (starve_cnt != Limit)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Registered responses; data and error hold until that port's next response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_o <= 2'b00;
      rsp_err_o   <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        rsp_data_o[n] <= 32'h0;
      end
    end else begin
      rsp_valid_o <= xfer;
      for (int n = 0; n < 2; n++) begin
        if (xfer[n]) begin
          rsp_data_o[n] <= we_i[n] ? 32'h0 : mem_rdata_i;
          rsp_err_o[n]  <= mem_align_err_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a behavioural model of the
// arbitration rules and a byte-array memory, plus literal expectations.
module tb_dmem_arbiter;
  import config_pkg::*;

  localparam int STARVE = 4;
  localparam int AW     = DMemAddrWidth;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]    req, lock, we, sext;
  mem_width_t    width [2];
  logic [AW-1:0] addr  [2];
  logic [31:0]   wdata [2];
  logic [1:0]    gnt, rsp_valid, rsp_err, dbg_state;
  logic [31:0]   rsp_data [2];
  logic          mem_we, mem_sext, mem_align_err;
  mem_width_t    mem_width;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  dmem_arbiter #(.StarveLimit(STARVE), .AddrWidth(AW)) dut (
    .clk(clk), .reset(rst),
    .req_i(req), .lock_i(lock), .we_i(we), .width_i(width), .sext_i(sext),
    .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .mem_we_o(mem_we), .mem_width_o(mem_width), .mem_sext_o(mem_sext),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_align_err_i(mem_align_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- memory environment ----------------
  logic [7:0] mem [0:4095];
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    b0 = mem[mem_addr];
    b1 = mem[mem_addr + 12'd1];
    b2 = mem[mem_addr + 12'd2];
    b3 = mem[mem_addr + 12'd3];
    mem_rdata     = 32'h0;
    mem_align_err = 1'b0;
    case (mem_width)
      BYTE:     mem_rdata = mem_sext ? {{24{b0[7]}}, b0} : {24'h0, b0};
      HALFWORD: begin
        mem_rdata     = mem_sext ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
        mem_align_err = mem_addr[0];
      end
      WORD: begin
        mem_rdata     = {b3, b2, b1, b0};
        mem_align_err = (mem_addr[1:0] != 2'b00);
      end
      default: mem_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_width != BYTE) mem[mem_addr + 12'd1] <= mem_wdata[15:8];
      if (mem_width == WORD) begin
        mem[mem_addr + 12'd2] <= mem_wdata[23:16];
        mem[mem_addr + 12'd3] <= mem_wdata[31:24];
      end
    end
  end

  function automatic logic [31:0] env_word(input logic [AW-1:0] a);
    return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
  endfunction

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  ref_mem [0:4095];
  int          m_owner;          // -1 none, else port holding the lock
  int          m_cnt;            // consecutive port-0 wins while port 1 waits
  logic [1:0]  m_rv;
  logic [31:0] m_rd [2];
  logic        m_re [2];

  function automatic logic m_misaligned(input mem_width_t w, input logic [AW-1:0] a);
    if (w == HALFWORD) return a[0];
    if (w == WORD) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input mem_width_t w, input logic s, input logic [AW-1:0] a);
    logic [31:0] v;
    v = {ref_mem[a + 12'd3], ref_mem[a + 12'd2], ref_mem[a + 12'd1], ref_mem[a]};
    if (w == BYTE) return s ? 32'(signed'(v[7:0])) : {24'h0, v[7:0]};
    if (w == HALFWORD) return s ? 32'(signed'(v[15:0])) : {16'h0, v[15:0]};
    return v;
  endfunction

  task automatic m_write(input mem_width_t w, input logic [AW-1:0] a, input logic [31:0] d);
    int nb;
    nb = (w == BYTE) ? 1 : (w == HALFWORD) ? 2 : 4;
    for (int i = 0; i < nb; i++) ref_mem[a + AW'(i)] = d[8*i +: 8];
  endtask

  // compare process: checks every cycle, then advances the model over the edge
  always @(negedge clk) begin : compare
    logic [1:0] eg;
    int         g;
    logic       mis, ewe;
    if (rst) begin
      m_owner = -1;
      m_cnt   = 0;
      m_rv    = 2'b00;
    end else begin
      if (m_owner == 0)      eg = {1'b0, req[0]};
      else if (m_owner == 1) eg = {req[1], 1'b0};
      else if (req == 2'b11) eg = (m_cnt == STARVE) ? 2'b10 : 2'b01;
      else                   eg = req;
      g   = eg[1] ? 1 : 0;
      mis = m_misaligned(width[g], addr[g]);
      ewe = (eg != 2'b00) && we[g];
`ifdef DMEM_ARB_ALIGN_BLOCK_EN
      if (mis) ewe = 1'b0;
`endif
      chk("gnt", 32'(gnt), 32'(eg));
      chk("mem_we", 32'(mem_we), 32'(ewe));
      chk("mem_addr", 32'(mem_addr), (eg != 2'b00) ? 32'(addr[g]) : 32'h0);
      chk("mem_wdata", mem_wdata, (eg != 2'b00) ? wdata[g] : 32'h0);
      if (eg != 2'b00) chk("mem_width", 32'(mem_width), 32'(width[g]));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      for (int n = 0; n < 2; n++) begin
        if (m_rv[n]) begin
          chk($sformatf("rsp_data%0d", n), rsp_data[n], m_rd[n]);
          chk($sformatf("rsp_err%0d", n), 32'(rsp_err[n]), 32'(m_re[n]));
        end
      end
      // advance model across the coming edge
      m_rv = eg;
      if (eg != 2'b00) begin
        m_rd[g] = we[g] ? 32'h0 : m_read(width[g], sext[g], addr[g]);
        m_re[g] = mis;
        if (ewe) m_write(width[g], addr[g], wdata[g]);
        if (lock[g]) m_owner = g;
        else if (m_owner == g) m_owner = -1;
      end
      if (eg[1] || !req[1]) m_cnt = 0;
      else if (eg[0]) m_cnt = (m_cnt + 1 > STARVE) ? STARVE : m_cnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_p(input int p, input logic r, input logic l, input logic w,
                       input mem_width_t wd, input logic s, input logic [AW-1:0] a,
                       input logic [31:0] d);
    req[p] = r; lock[p] = l; we[p] = w; width[p] = wd; sext[p] = s;
    addr[p] = a; wdata[p] = d;
  endtask

  task automatic idle_all();
    for (int p = 0; p < 2; p++) set_p(p, 1'b0, 1'b0, 1'b0, BYTE, 1'b0, '0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_all();
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data0", rsp_data[0], 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'h0);
    step();
    rst = 1'b0;

    // word write then signed byte load
    set_p(0, 1, 0, 1, WORD, 0, 12'h010, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_gnt_wr", 32'(gnt), 32'h1);
    chk("t1_we", 32'(mem_we), 32'h1);
    step();
    set_p(0, 1, 0, 0, BYTE, 1, 12'h013, 32'h0);
    @(negedge clk);
    chk("t1_gnt_rd", 32'(gnt), 32'h1);
    chk("t1_wr_rsp_data", rsp_data[0], 32'h0);
    step();
    idle_all();
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid[0]), 32'h1);
    chk("t1_rsp_data", rsp_data[0], 32'hFFFFFFDE);
    chk("t1_rsp_err", 32'(rsp_err[0]), 32'h0);
    step();

    // both ports requesting continuously: starvation guard pattern
    set_p(0, 1, 0, 0, WORD, 0, 12'h040, 32'h0);
    set_p(1, 1, 0, 0, WORD, 0, 12'h044, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t2_gnt_%0d", i), 32'(gnt), (i % 5 == 4) ? 32'h2 : 32'h1);
      step();
    end
    idle_all();
    step();

    // port 1 locked read-modify-write
    set_p(1, 1, 1, 0, WORD, 0, 12'h020, 32'h0);
    @(negedge clk);
    chk("t3_gnt_lock", 32'(gnt), 32'h2);
    step();
    set_p(1, 1, 0, 1, WORD, 0, 12'h020, 32'h5);
    set_p(0, 1, 0, 0, WORD, 0, 12'h030, 32'h0);
    @(negedge clk);
    chk("t3_gnt_store", 32'(gnt), 32'h2);
    chk("t3_state", 32'(dbg_state), 32'h2);
    step();
    set_p(1, 0, 0, 0, BYTE, 0, '0, 32'h0);
    @(negedge clk);
    chk("t3_gnt_after", 32'(gnt), 32'h1);
    chk("t3_rsp1_valid", 32'(rsp_valid[1]), 32'h1);
    step();
    idle_all();
    @(negedge clk);
    chk("t3_mem_word", env_word(12'h020), 32'h5);
    step();

    // misaligned halfword write
    set_p(0, 1, 0, 1, WORD, 0, 12'h020, 32'h11223344);
    step();
    set_p(0, 1, 0, 1, HALFWORD, 0, 12'h021, 32'h0000ABCD);
    @(negedge clk);
`ifdef DMEM_ARB_ALIGN_BLOCK_EN
    chk("t4_we_blocked", 32'(mem_we), 32'h0);
`else
    chk("t4_we_pass", 32'(mem_we), 32'h1);
`endif
    step();
    idle_all();
    @(negedge clk);
    chk("t4_rsp_valid", 32'(rsp_valid[0]), 32'h1);
    chk("t4_rsp_err", 32'(rsp_err[0]), 32'h1);
`ifdef DMEM_ARB_ALIGN_BLOCK_EN
    chk("t4_mem_word", env_word(12'h020), 32'h11223344);
`else
    chk("t4_mem_word", env_word(12'h020), 32'h11ABCD44);
`endif
    step();

    // reset while locked with a response pending
    set_p(0, 1, 1, 0, BYTE, 0, 12'h010, 32'h0);
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    #1;
    chk("t5_pending", 32'(rsp_valid[0]), 32'h1);
    chk("t5_locked", 32'(dbg_state), 32'h1);
    idle_all();
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(rsp_valid), 32'h0);
    chk("t5_async_state", 32'(dbg_state), 32'h0);
    step();
    rst = 1'b0;
    set_p(1, 1, 0, 0, WORD, 0, 12'h044, 32'h0);
    @(negedge clk);
    chk("t5_p1_gnt", 32'(gnt), 32'h2);
    step();
    idle_all();

    // idle cycles
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_gnt", 32'(gnt), 32'h0);
      chk("t6_we", 32'(mem_we), 32'h0);
      chk("t6_addr", 32'(mem_addr), 32'h0);
      chk("t6_valid", 32'(rsp_valid), 32'h0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
